// File: rtl/uart_rx_fifo_feeder.sv
// UART receiver: 2-flop rx sync, 16x oversampling tick generator and
// start/data/stop deframer writing each received word into a downstream FIFO.
module uart_rx_fifo_feeder #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int DVSR    = 163,
   parameter int DVSR_W  = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            full,
   output logic            wr,
   output logic [DBIT-1:0] wdata,
   output logic            frame_err,
   output logic            overrun,
   output logic            busy
);

   localparam int NW = $clog2(DBIT);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] BRK   = 3'd4;

   logic              rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
   logic [DVSR_W-1:0] cnt_q, cnt_d;
   logic              tick;
   logic [2:0]        state_q, state_d;
   logic [4:0]        s_q, s_d;
   logic [NW-1:0]     n_q, n_d;
   logic [DBIT-1:0]   b_q, b_d;
   logic              wr_q, wr_d, fe_q, fe_d, ov_q, ov_d, busy_q, busy_d;

   assign tick = (cnt_q == DVSR_W'(DVSR - 1));

   always_comb begin
      rx_meta_d = rx;
      rx_s_d    = rx_meta_q;
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      state_d   = state_q;
      s_d       = s_q;
      n_d       = n_q;
      b_d       = b_q;
      wr_d      = 1'b0;
      fe_d      = 1'b0;
      ov_d      = 1'b0;
      case (state_q)
         // Start edge is checked every clk so back-to-back frames are not missed.
         IDLE: if (!rx_s_q) begin
            state_d = START;
            s_d     = '0;
         end
         START: if (tick) begin
            if (s_q == 5'd7) begin
               if (!rx_s_q) begin
                  state_d = DATA;
                  s_d     = '0;
                  n_d     = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               s_d = s_q + 1'b1;
            end
         end
         DATA: if (tick) begin
            if (s_q == 5'd15) begin
               s_d = '0;
               b_d = {rx_s_q, b_q[DBIT-1:1]};
               if (n_q == NW'(DBIT - 1)) state_d = STOP;
               else                      n_d = n_q + 1'b1;
            end else begin
               s_d = s_q + 1'b1;
            end
         end
         STOP: if (tick) begin
            if (s_q == 5'(SB_TICK - 1)) begin
               if (rx_s_q) begin
                  wr_d    = !full;
                  ov_d    = full;
                  state_d = IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = BRK;
               end
            end else begin
               s_d = s_q + 1'b1;
            end
         end
         // A held-low line must return high before another start is accepted.
         BRK: if (rx_s_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         cnt_q     <= '0;
         state_q   <= IDLE;
         s_q       <= '0;
         n_q       <= '0;
         b_q       <= '0;
         wr_q      <= 1'b0;
         fe_q      <= 1'b0;
         ov_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         s_q       <= s_d;
         n_q       <= n_d;
         b_q       <= b_d;
         wr_q      <= wr_d;
         fe_q      <= fe_d;
         ov_q      <= ov_d;
         busy_q    <= busy_d;
      end
   end

   assign wr        = wr_q;
   assign wdata     = b_q;
   assign frame_err = fe_q;
   assign overrun   = ov_q;
   assign busy      = busy_q;

endmodule

// File: doc/uart_rx_fifo_feeder.md
Name: uart_rx_fifo_feeder

Overview:
UART receive front end: oversamples the serial input and deframes start / DBIT data (LSB first) / stop. Each completed byte is written into the downstream receive FIFO through its wr/wdata/full interface. The block contains its own 16x baud-tick generator. It reports framing errors and FIFO overruns as single-cycle pulses.

Parameters:
DBIT, 8, number of data bits per frame (2..16).
SB_TICK, 16, oversample ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
DVSR, 163, clk cycles per oversample tick (16x baud). 163 gives 19200 baud at 50 MHz.
DVSR_W, 8, width of the tick divider counter; must satisfy 2**DVSR_W >= DVSR.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
rx  in  1  serial input, idle high, asynchronous to clk.
full  in  1  downstream FIFO full flag.
wr  out  1  one-cycle write strobe to the FIFO.
wdata  out  DBIT  received byte; stable whenever wr=1.
frame_err  out  1  one-cycle pulse: stop bit sampled low.
overrun  out  1  one-cycle pulse: valid byte dropped because full=1.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: async, active-high; clock clk. Reset values:
  - wr = frame_err = overrun = 0; busy = 0; wdata = 0.
  - FSM = IDLE; tick counter = 0; sample counter s = 0; bit counter n = 0.
  - Both rx synchronizer flops = 1.
- Input sync: rx passes through 2 flops (rx_s). Every FSM decision uses rx_s only.
- Tick generator: free-running counter 0..DVSR-1 that wraps to 0. tick = 1 for the one cycle where count == DVSR-1. It runs regardless of FSM state.
- Counters: s is 5 bits and counts ticks within the current bit. n counts 0..DBIT-1. Shift register b is DBIT wide and drives wdata directly.
- FSM states are IDLE, START, DATA, STOP, BRK. Transitions:
  - IDLE: when rx_s == 0 (checked every clk, not only on tick), go to START with s = 0.
  - START: on tick with s == 7 (mid start bit): if rx_s == 0, go to DATA with s = 0, n = 0; otherwise treat it as a glitch and go to IDLE with no pulse. On other ticks, s++.
  - DATA: on tick with s == 15: set s = 0 and b = {rx_s, b[DBIT-1:1]} (LSB first). If n == DBIT-1, go to STOP; else n++. On other ticks, s++.
  - STOP: on tick with s == SB_TICK-1, sample rx_s:
    - rx_s = 1 and full = 0: assert wr; go to IDLE.
    - rx_s = 1 and full = 1: assert overrun, no wr; go to IDLE.
    - rx_s = 0: assert frame_err, no wr; go to BRK.
    - On other ticks, s++.
  - BRK: stay until rx_s == 1, then go to IDLE. This prevents a held-low line (break) from producing repeated frames.
- Output pulses: wr, frame_err and overrun are registered. They are high for exactly one clk, the cycle after the completing tick. At most one of the three is high in any cycle.
- wdata: b changes only in DATA, so wdata holds the last received byte until the next frame's first data sample. On an overrun or frame error, b still holds the received bits.
- full: sampled only in the completing-tick cycle. Changes of full at any other time have no effect.
- Latency, rx falling edge to wr:
  - 2 clk of synchronization plus 0..DVSR-1 clk of tick phase;
  - then 8 + 16*DBIT + SB_TICK ticks;
  - then 1 clk for the output register.
- Back-to-back frames: a start edge arriving immediately after stop completion is accepted; IDLE checks rx_s in the very next cycle.
- busy = (state != IDLE), registered with the state.
- Reset mid-frame: immediate abort to the reset values, no pulse emitted. The next valid frame after release is received correctly.
- Receiver tolerance: the sample point is mid-bit ±1 tick; a baud mismatch of up to ±3% must still decode correctly.

Test Plan:
(Sim settings: DVSR = 4, one bit = 64 clk, full = 0 unless stated.)
1. Send 8'hA5 with stop = 1 -> exactly one wr pulse with wdata = 8'hA5; frame_err = 0, overrun = 0; busy falls to 0 in the cycle after the STOP→IDLE tick.
2. Pulse rx low for 12 clk (3 ticks), then high -> no wr and no error pulses; busy returns to 0 about 8 ticks after the edge.
3. Send 8'h3C with stop bit = 0, hold rx low for 5 more bit times, then high, then send 8'h55 -> one frame_err pulse with no wr; no further pulses during the low period; then a single wr with wdata = 8'h55.
4. full = 1 during the stop bit of 8'h81 -> one overrun pulse, no wr, wdata = 8'h81. Repeat with full = 1 only during DATA and 0 at stop -> wr asserted.
5. Send 8'h00 and 8'hFF back-to-back with no idle gap; also repeat with rx at a baud period +3% and -3% -> two wr pulses per run, values 8'h00 then 8'hFF.
6. Assert reset during the DATA bit 4 of 8'hF0 -> all outputs 0 and busy = 0 immediately, no pulse; after release, 8'h5A is received with a single wr pulse.
